// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: takes WIDTH-bit words over valid/ready and shifts
// them out one bit per clock on x, with a one-word hold register for gapless streaming.
module bit_serializer #(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_PEN  = CW'(WIDTH - 2);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] shift_r;
  logic [WIDTH-1:0] hold_r;
  logic             hold_full_r;
  logic [CW-1:0]    cnt_r;
  logic             accept_s;
  logic [WIDTH-1:0] load_word_s;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign accept_s    = din_valid & din_ready;
  // A buffered word always has priority; din_ready is low while it is present.
  assign load_word_s = hold_full_r ? hold_r : din;

  // Serializer FSM: shifter, bit counter, hold register and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      shift_r     <= '0;
      hold_r      <= '0;
      hold_full_r <= 1'b0;
      cnt_r       <= '0;
      x           <= IDLE_BIT;
      x_valid     <= 1'b0;
      last        <= 1'b0;
      din_ready   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r <= SHIFT;
            x       <= first_bit(din);
            shift_r <= shift_out(din);
            cnt_r   <= '0;
            x_valid <= 1'b1;
            last    <= 1'b0;
          end else begin
            x       <= IDLE_BIT;
            x_valid <= 1'b0;
            last    <= 1'b0;
          end
          din_ready <= 1'b1;
        end
        SHIFT: begin
          if (cnt_r == CNT_LAST) begin
            if (hold_full_r || accept_s) begin
              x           <= first_bit(load_word_s);
              shift_r     <= shift_out(load_word_s);
              cnt_r       <= '0;
              x_valid     <= 1'b1;
              last        <= 1'b0;
              hold_full_r <= 1'b0;
            end else begin
              state_r <= IDLE;
              x       <= IDLE_BIT;
              x_valid <= 1'b0;
              last    <= 1'b0;
            end
            din_ready <= 1'b1;
          end else begin
            x       <= first_bit(shift_r);
            shift_r <= shift_out(shift_r);
            cnt_r   <= cnt_r + CW'(1);
            x_valid <= 1'b1;
            last    <= (cnt_r == CNT_PEN);
            if (accept_s) begin
              hold_r      <= din;
              hold_full_r <= 1'b1;
              din_ready   <= 1'b0;
            end else begin
              din_ready <= ~hold_full_r;
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          hold_full_r <= 1'b0;
          x           <= IDLE_BIT;
          x_valid     <= 1'b0;
          last        <= 1'b0;
          din_ready   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: bit-queue reference model compared every
// cycle, plus hand-computed literal expectations for each directed scenario.
module tb_bit_serializer;
  localparam int W = 8;

  logic         clk       = 1'b0;
  logic         reset     = 1'b0;
  logic [W-1:0] din       = '0;
  logic         din_valid = 1'b0;

  logic ready_m, x_m, xv_m, last_m;
  logic ready_l, x_l, xv_l, last_l;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(ready_m), .x(x_m), .x_valid(xv_m), .last(last_m)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(ready_l), .x(x_l), .x_valid(xv_l), .last(last_l)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: every accepted word becomes W queued bits; one bit leaves per cycle.
  logic [1:0] qm[$];
  logic [1:0] ql[$];
  logic ex_x_m  = 1'b0;
  logic ex_x_l  = 1'b0;
  logic ex_valid = 1'b0;
  logic ex_last  = 1'b0;
  logic ex_ready = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      qm.delete();
      ql.delete();
      ex_x_m   <= 1'b0;
      ex_x_l   <= 1'b0;
      ex_valid <= 1'b0;
      ex_last  <= 1'b0;
      ex_ready <= 1'b0;
    end else begin
      if (din_valid && ex_ready) begin
        for (int i = 0; i < W; i++) begin
          qm.push_back({(i == W - 1), din[W-1-i]});
          ql.push_back({(i == W - 1), din[i]});
        end
      end
      if (qm.size() > 0) begin
        ex_x_m   <= qm[0][0];
        ex_last  <= qm[0][1];
        ex_x_l   <= ql[0][0];
        ex_valid <= 1'b1;
        qm.delete(0);
        ql.delete(0);
      end else begin
        ex_x_m   <= 1'b0;
        ex_x_l   <= 1'b0;
        ex_last  <= 1'b0;
        ex_valid <= 1'b0;
      end
      ex_ready <= (int'(qm.size()) < W);
    end
  end

  // Cumulative capture of transmitted bits for the literal checks.
  logic [31:0] cap_m = '0;
  logic [31:0] cap_l = '0;
  int nbits = 0;
  int nlast = 0;
  int nlow  = 0;

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    check("x_valid_msb", xv_m, ex_valid);
    check("x_msb", x_m, ex_x_m);
    check("last_msb", last_m, ex_last);
    check("din_ready_msb", ready_m, ex_ready);
    check("x_valid_lsb", xv_l, ex_valid);
    check("x_lsb", x_l, ex_x_l);
    check("last_lsb", last_l, ex_last);
    check("din_ready_lsb", ready_l, ex_ready);
    if (xv_m) begin
      cap_m <= {cap_m[30:0], x_m};
      nbits <= nbits + 1;
    end
    if (xv_l) cap_l <= {cap_l[30:0], x_l};
    if (last_m) nlast <= nlast + 1;
    if (reset && !ready_m) nlow <= nlow + 1;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [W-1:0] w);
    din       = w;
    din_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (ready_m) begin
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    check("send_timeout", 32'd1, 32'd0);
  endtask

  int b0, l0, n0;

  initial begin
    cyc(2);
    check("rst_x", x_m, 32'd0);
    check("rst_x_valid", xv_m, 32'd0);
    check("rst_last", last_m, 32'd0);
    check("rst_din_ready", ready_m, 32'd0);
    reset = 1'b1;
    #1 check("ready_before_edge", ready_m, 32'd0);
    cyc(1);
    check("ready_after_edge", ready_m, 32'd1);

    // Single word, MSB first: 1,0,1,0,0,1,0,1 with one last pulse.
    b0 = nbits; l0 = nlast;
    send(8'hA5);
    din_valid = 1'b0;
    cyc(10);
    check("single_nbits", 32'(nbits - b0), 32'd8);
    check("single_bits_msb", cap_m & 32'hFF, 32'hA5);
    check("single_bits_lsb", cap_l & 32'hFF, 32'hA5);
    check("single_nlast", 32'(nlast - l0), 32'd1);
    check("single_idle_valid", xv_m, 32'd0);
    check("single_idle_x", x_m, 32'd0);

    // 8'h01: LSB-first sends 1 first, MSB-first sends it last.
    send(8'h01);
    din_valid = 1'b0;
    cyc(10);
    check("order_msb", cap_m & 32'hFF, 32'h01);
    check("order_lsb", cap_l & 32'hFF, 32'h80);

    // Back-to-back: 16 contiguous bits, hold reg full for 7 cycles.
    b0 = nbits; l0 = nlast; n0 = nlow;
    send(8'hA5);
    send(8'h3C);
    din_valid = 1'b0;
    cyc(20);
    check("b2b_nbits", 32'(nbits - b0), 32'd16);
    check("b2b_bits", cap_m & 32'hFFFF, 32'hA53C);
    check("b2b_nlast", 32'(nlast - l0), 32'd2);
    check("b2b_ready_low", 32'(nlow - n0), 32'd7);

    // Stall: changing din while din_ready=0 must never be transmitted.
    b0 = nbits;
    send(8'hC3);
    send(8'h96);
    for (int i = 0; i < 20; i++) begin
      if (ready_m) break;
      din       = 8'($urandom);
      din_valid = 1'b1;
      cyc(1);
    end
    send(8'h5A);
    din_valid = 1'b0;
    cyc(30);
    check("stall_nbits", 32'(nbits - b0), 32'd24);
    check("stall_bits", cap_m & 32'hFFFFFF, 32'hC3965A);

    // Mid-word reset with a held word: outputs idle at once, nothing resumes.
    send(8'hF0);
    send(8'h0F);
    din_valid = 1'b0;
    cyc(2);
    #2 reset = 1'b0;
    #1;
    check("midrst_x", x_m, 32'd0);
    check("midrst_x_valid", xv_m, 32'd0);
    check("midrst_last", last_m, 32'd0);
    check("midrst_ready", ready_m, 32'd0);
    check("midrst_x_valid_lsb", xv_l, 32'd0);
    cyc(2);
    reset = 1'b1;
    b0 = nbits;
    cyc(15);
    check("post_rst_silent", 32'(nbits - b0), 32'd0);
    send(8'h81);
    din_valid = 1'b0;
    cyc(12);
    check("post_rst_nbits", 32'(nbits - b0), 32'd8);
    check("post_rst_word", cap_m & 32'hFF, 32'h81);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
